// File: rtl/i2c_master_ctrl.sv
// Single-transaction I2C master: START, device id, R/W, ACK, address, ACK, data, ACK, STOP.
// One bit slot is 2*CLK_DIV clocks; SDA moves mid-low, SDA is sampled mid-high.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [7:0] req_dev_id,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_out,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int unsigned SLOT = 2 * CLK_DIV;
    localparam int unsigned PW   = $clog2(SLOT);
    localparam logic [PW-1:0] P_ONE    = PW'(1);
    localparam logic [PW-1:0] P_LAST   = PW'(SLOT - 1);
    localparam logic [PW-1:0] P_HIGH   = PW'(CLK_DIV);
    localparam logic [PW-1:0] P_DRIVE  = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] P_SAMPLE = PW'(CLK_DIV + CLK_DIV / 2);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV, S_RW, S_ACK1, S_ADDR, S_ACK2, S_DATA, S_ACK3, S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    dev_q, dev_d, addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic          rw_q, rw_d, err_q, err_d, hold_q, hold_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          accept, slot_end, sample, slot_drive;

    assign accept   = req_valid && (state_q == S_IDLE);
    assign slot_end = (phase_q == P_LAST);
    assign sample   = (phase_q == P_SAMPLE);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            dev_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            err_q       <= 1'b0;
            hold_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            dev_q       <= dev_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            err_q       <= err_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        if (state_q == S_IDLE) begin
            phase_d = '0;
            bit_d   = '0;
            if (req_valid) state_d = S_START;
        end else begin
            phase_d = slot_end ? '0 : phase_q + P_ONE;
            if (slot_end) begin
                // bit_q wraps 7 -> 0 on the last bit, ready for the next byte field
                case (state_q)
                    S_START: state_d = S_DEV;
                    S_DEV: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_RW;
                    end
                    S_RW:   state_d = S_ACK1;
                    S_ACK1: state_d = err_q ? S_STOP : S_ADDR;
                    S_ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_ACK2;
                    end
                    S_ACK2: state_d = err_q ? S_STOP : S_DATA;
                    S_DATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_ACK3;
                    end
                    S_ACK3:  state_d = S_STOP;
                    S_STOP:  state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        dev_d       = dev_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rw_d        = rw_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        if (accept) begin
            dev_d   = req_dev_id;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            rw_d    = req_rw;
            err_d   = 1'b0;
            rdata_d = '0;
        end
        if (sample) begin
            case (state_q)
                S_ACK1, S_ACK2: if (sda_in) err_d = 1'b1;
                S_ACK3:         if (!rw_q && sda_in) err_d = 1'b1;
                S_DATA:         if (rw_q) rdata_d = {rdata_q[6:0], sda_in};
                default:        ;
            endcase
        end
        // SDA level at the end of a slot carries over until the next mid-low point
        if (slot_end) hold_d = sda_oe;
        if (state_q == S_STOP && slot_end) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rdata_d = (rw_q && !err_q) ? rdata_q : '0;
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        slot_drive = 1'b0;
        case (state_q)
            S_DEV:   slot_drive = ~dev_q[3'd7 - bit_q];
            S_RW:    slot_drive = ~rw_q;
            S_ADDR:  slot_drive = ~addr_q[3'd7 - bit_q];
            S_DATA:  slot_drive = ~rw_q & ~wdata_q[3'd7 - bit_q];
            S_ACK3:  slot_drive = rw_q;
            default: slot_drive = 1'b0;
        endcase
        scl_out = 1'b1;
        sda_oe  = 1'b0;
        case (state_q)
            S_IDLE: begin
                scl_out = 1'b1;
                sda_oe  = 1'b0;
            end
            S_START: begin
                scl_out = 1'b1;
                sda_oe  = (phase_q >= P_HIGH);
            end
            S_STOP: begin
                scl_out = (phase_q >= P_HIGH);
                sda_oe  = (phase_q < P_SAMPLE);
            end
            default: begin
                scl_out = (phase_q >= P_HIGH);
                sda_oe  = (phase_q >= P_DRIVE) ? slot_drive : hold_q;
            end
        endcase
    end

endmodule
